instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//   Instruction queue between instruction memory (fetch) and the control unit (decode).
//   Buffers fetched {pc, instr} pairs in order, decouples fetch and decode with valid/ready handshakes,
//   and presents the pre-split decode fields (op, funct3, funct7) that the decode stage consumes.
//   Branch/jump redirects empty it through a synchronous flush.
// PARAMETERS
//   DEPTH  4   number of entries; power of 2, >= 2
//   XLEN   32  width of pc and instruction words
// PORTS
//   clk_i       in   1          clock, all state updates on rising edge
//   reset_n_i   in   1          synchronous, active-low reset
//   pc_f_i      in   XLEN       pc of fetched instruction
//   instr_f_i   in   XLEN       fetched instruction word
//   valid_f_i   in   1          fetch side offers pc_f_i/instr_f_i
//   ready_f_o   out  1          queue can accept an entry this cycle
//   valid_d_o   out  1          head entry is valid for decode
//   ready_d_i   in   1          decode consumes head entry this cycle
//   pc_d_o      out  XLEN       pc of head entry
//   instr_d_o   out  XLEN       head instruction word
//   op_d_o      out  7          instr_d_o[6:0]
//   funct3_d_o  out  3          instr_d_o[14:12]
//   funct7_d_o  out  7          instr_d_o[31:25]
//   flush_i     in   1          discard all entries (redirect)
//   count_o     out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
// BEHAVIOUR
//   - Storage: DEPTH-entry circular array of {pc, instr}; write ptr, read ptr, occupancy counter.
//   - push = valid_f_i & ready_f_o; pop = valid_d_o & ready_d_i.
//   - ready_f_o = (count != DEPTH). No pop-through when full: a full queue refuses a push even if a pop occurs that cycle.
//   - valid_d_o = (count != 0). Head fields are driven combinationally from the stored head entry.
//   - Latency: entry pushed at edge N is visible at outputs after edge N (1 cycle). No empty bypass.
//   - When empty: instr_d_o = 32'h0000_0013 (NOP), pc_d_o = 0. op/funct3/funct7 follow instr_d_o (op = 7'h13).
//   - Push only: write entry, wr_ptr+1, count+1. Pop only: rd_ptr+1, count-1.
//   - Push and pop in the same cycle: both pointers advance, count unchanged, order preserved.
//   - Pointers wrap modulo DEPTH. No overflow/underflow: the handshake gating makes illegal push/pop no-ops.
//   - Flush (priority over push/pop): next edge sets wr_ptr = rd_ptr = 0 and count = 0. A push or pop in
//     the flush cycle is discarded. A push is accepted again the cycle after flush (ready_f_o = 1).
//   - Reset (reset_n_i = 0 at edge, priority over flush): ptrs = 0, count = 0. Resulting outputs:
//     valid_d_o = 0, ready_f_o = 1, count_o = 0, instr_d_o = 0x00000013, pc_d_o = 0.
//     Reset mid-operation drops all entries. Array contents are not reset.
//   - Outputs while valid_d_o = 0 are don't-care to decode, but must still equal the NOP/0 values above.
// TESTING
//   1 reset: hold reset_n_i=0 2 cycles with valid_f_i=1 -> valid_d_o=0, ready_f_o=1, count_o=0,
//     instr_d_o=0x00000013, op_d_o=0x13.
//   2 fill: ready_d_i=0, push pc 0x0,0x4,0x8,0xC with instr 0x00500093,0x40208033,0x00112023,0x00000063
//     -> count_o=4, ready_f_o=0; 5th push (pc 0x10) ignored, count_o stays 4.
//   3 drain: ready_d_i=1 -> pc_d_o 0x0,0x4,0x8,0xC over 4 cycles. At pc 0x4: op_d_o=0x33, funct3_d_o=0,
//     funct7_d_o=0x20. Then valid_d_o=0, instr_d_o=0x00000013.
//   4 simultaneous/wrap: at count=2, push+pop every cycle for 8 cycles -> count_o stays 2, pc order strictly
//     ascending, pointers wrap twice.
//   5 flush: at count=3, flush_i=1 with valid_f_i=1 (pc 0x40) -> next cycle count_o=0, valid_d_o=0.
//     pc 0x40 never appears. A push on the following cycle appears after 1 cycle.
//   6 reset mid-op: count=3, reset_n_i=0 one cycle -> count_o=0, valid_d_o=0, ready_f_o=1.
//     New pushes are delivered in order.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - in-order {pc, instr} queue between fetch and decode with flush
module instr_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [XLEN-1:0]   pc_f_i,
    input  logic [XLEN-1:0]   instr_f_i,
    input  logic              valid_f_i,
    output logic              ready_f_o,
    output logic              valid_d_o,
    input  logic              ready_d_i,
    output logic [XLEN-1:0]   pc_d_o,
    output logic [XLEN-1:0]   instr_d_o,
    output logic [6:0]        op_d_o,
    output logic [2:0]        funct3_d_o,
    output logic [6:0]        funct7_d_o,
    input  logic              flush_i,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]   FULL_COUNT = CW'(DEPTH);
    localparam logic [XLEN-1:0] NOP_INSTR  = XLEN'(32'h0000_0013);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [XLEN-1:0] instr_mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic push;
    logic pop;

    // A full queue refuses pushes even when decode pops in the same cycle.
    assign ready_f_o = (count != FULL_COUNT);
    assign valid_d_o = (count != '0);
    assign push      = valid_f_i & ready_f_o;
    assign pop       = valid_d_o & ready_d_i;
    assign count_o   = count;

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is intentionally not reset; occupancy alone defines validity.
    always_ff @(posedge clk_i) begin
        if (reset_n_i && !flush_i && push) begin
            pc_mem[wr_ptr]    <= pc_f_i;
            instr_mem[wr_ptr] <= instr_f_i;
        end
    end

    always_comb begin
        pc_d_o    = '0;
        instr_d_o = NOP_INSTR;
        if (valid_d_o) begin
            pc_d_o    = pc_mem[rd_ptr];
            instr_d_o = instr_mem[rd_ptr];
        end
    end

    assign op_d_o     = instr_d_o[6:0];
    assign funct3_d_o = instr_d_o[14:12];
    assign funct7_d_o = instr_d_o[31:25];

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - randomized self-checking bench for instr_fetch_queue
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;
    localparam int XLEN  = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc_f = '0;
    logic [31:0] instr_f = '0;
    logic        valid_f = 1'b0;
    logic        ready_f;
    logic        valid_d;
    logic        ready_d = 1'b0;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic [6:0]  op_d;
    logic [2:0]  funct3_d;
    logic [6:0]  funct7_d;
    logic        flush = 1'b0;
    logic [2:0]  count;

    int unsigned passed = 0;
    int unsigned total  = 0;

    logic [63:0] mq[$];

    always #5 clk = ~clk;

    instr_fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk_i      (clk),
        .reset_n_i  (reset_n),
        .pc_f_i     (pc_f),
        .instr_f_i  (instr_f),
        .valid_f_i  (valid_f),
        .ready_f_o  (ready_f),
        .valid_d_o  (valid_d),
        .ready_d_i  (ready_d),
        .pc_d_o     (pc_d),
        .instr_d_o  (instr_d),
        .op_d_o     (op_d),
        .funct3_d_o (funct3_d),
        .funct7_d_o (funct7_d),
        .flush_i    (flush),
        .count_o    (count)
    );

    // Drive one cycle of stimulus, let the edge happen, update the reference queue, return at negedge.
    task automatic cycle(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rd, input logic fl, input logic rn);
        logic do_push;
        logic do_pop;
        valid_f = v; pc_f = pc; instr_f = ins; ready_d = rd; flush = fl; reset_n = rn;
        do_push = v && (mq.size() < DEPTH);
        do_pop  = rd && (mq.size() > 0);
        @(posedge clk);
        if (!rn || fl) begin
            mq.delete();
        end else begin
            if (do_pop)  void'(mq.pop_front());
            if (do_push) mq.push_back({pc, ins});
        end
        @(negedge clk);
        valid_f = 1'b0; ready_d = 1'b0; flush = 1'b0; reset_n = 1'b1;
    endtask

    function automatic logic [31:0] exp_pc();
        return (mq.size() > 0) ? mq[0][63:32] : 32'h0;
    endfunction

    function automatic logic [31:0] exp_instr();
        return (mq.size() > 0) ? mq[0][31:0] : 32'h0000_0013;
    endfunction

    task automatic test_reset();
        cycle(1'b1, 32'h80, 32'h1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h84, 32'h2, 1'b0, 1'b0, 1'b0);
        total++; if (valid_d !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_d); else passed++;
        total++; if (ready_f !== 1'b1) $display("FAIL reset_ready: got %b expected 1", ready_f); else passed++;
        total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d expected 0", count); else passed++;
        total++; if (instr_d !== 32'h13) $display("FAIL reset_instr: got %h expected 00000013", instr_d); else passed++;
        total++; if (op_d !== 7'h13) $display("FAIL reset_op: got %h expected 13", op_d); else passed++;
        total++; if (pc_d !== 32'h0) $display("FAIL reset_pc: got %h expected 0", pc_d); else passed++;
    endtask

    task automatic test_fill();
        logic [31:0] ins_tab [4];
        ins_tab = '{32'h00500093, 32'h40208033, 32'h00112023, 32'h00000063};
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 32'(i * 4), ins_tab[i], 1'b0, 1'b0, 1'b1);
            total++;
            if (count !== 3'(i + 1)) $display("FAIL fill_count_%0d: got %0d expected %0d", i, count, i + 1);
            else passed++;
        end
        total++; if (ready_f !== 1'b0) $display("FAIL fill_ready: got %b expected 0", ready_f); else passed++;
        cycle(1'b1, 32'h10, 32'h13, 1'b0, 1'b0, 1'b1);
        total++; if (count !== 3'd4) $display("FAIL fill_overflow_count: got %0d expected 4", count); else passed++;
        total++; if (pc_d !== 32'h0) $display("FAIL fill_head_pc: got %h expected 0", pc_d); else passed++;
    endtask

    task automatic test_drain();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (pc_d !== 32'(i * 4)) $display("FAIL drain_pc_%0d: got %h expected %h", i, pc_d, i * 4);
            else passed++;
            if (i == 1) begin
                total++; if (op_d !== 7'h33) $display("FAIL drain_op: got %h expected 33", op_d); else passed++;
                total++; if (funct3_d !== 3'h0) $display("FAIL drain_funct3: got %h expected 0", funct3_d); else passed++;
                total++; if (funct7_d !== 7'h20) $display("FAIL drain_funct7: got %h expected 20", funct7_d); else passed++;
            end
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        end
        total++; if (valid_d !== 1'b0) $display("FAIL drain_valid: got %b expected 0", valid_d); else passed++;
        total++; if (instr_d !== 32'h13) $display("FAIL drain_instr: got %h expected 00000013", instr_d); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] last_pc;
        cycle(1'b1, 32'h100, 32'h100 ^ 32'hA5A5_0000, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 32'h104, 32'h104 ^ 32'hA5A5_0000, 1'b0, 1'b0, 1'b1);
        last_pc = 32'h0FC;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (pc_d !== exp_pc() || pc_d <= last_pc)
                $display("FAIL b2b_pc_%0d: got %h expected %h", i, pc_d, exp_pc());
            else passed++;
            last_pc = pc_d;
            cycle(1'b1, 32'(32'h108 + i * 4), 32'(32'h108 + i * 4) ^ 32'hA5A5_0000, 1'b1, 1'b0, 1'b1);
            total++;
            if (count !== 3'd2) $display("FAIL b2b_count_%0d: got %0d expected 2", i, count);
            else passed++;
        end
        total++; if (instr_d !== exp_instr()) $display("FAIL b2b_instr: got %h expected %h", instr_d, exp_instr()); else passed++;
    endtask

    task automatic test_flush();
        cycle(1'b1, 32'h130, 32'h0000_0033, 1'b0, 1'b0, 1'b1);
        total++; if (count !== 3'd3) $display("FAIL flush_pre_count: got %0d expected 3", count); else passed++;
        cycle(1'b1, 32'h40, 32'h0000_0073, 1'b1, 1'b1, 1'b1);
        total++; if (count !== 3'd0) $display("FAIL flush_count: got %0d expected 0", count); else passed++;
        total++; if (valid_d !== 1'b0) $display("FAIL flush_valid: got %b expected 0", valid_d); else passed++;
        total++; if (ready_f !== 1'b1) $display("FAIL flush_ready: got %b expected 1", ready_f); else passed++;
        cycle(1'b1, 32'h200, 32'h0010_0093, 1'b0, 1'b0, 1'b1);
        total++; if (valid_d !== 1'b1 || pc_d !== 32'h200) $display("FAIL flush_repush: got valid %b pc %h expected valid 1 pc 00000200", valid_d, pc_d); else passed++;
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        total++; if (valid_d !== 1'b0) $display("FAIL flush_stale: got valid %b pc %h expected valid 0", valid_d, pc_d); else passed++;
    endtask

    task automatic test_reset_midop();
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'(32'h300 + i * 4), 32'(i + 1), 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++; if (count !== 3'd0) $display("FAIL rst_mid_count: got %0d expected 0", count); else passed++;
        total++; if (valid_d !== 1'b0) $display("FAIL rst_mid_valid: got %b expected 0", valid_d); else passed++;
        total++; if (ready_f !== 1'b1) $display("FAIL rst_mid_ready: got %b expected 1", ready_f); else passed++;
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'(32'h400 + i * 4), 32'(32'h400 + i), 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (pc_d !== 32'(32'h400 + i * 4) || instr_d !== 32'(32'h400 + i))
                $display("FAIL rst_mid_order_%0d: got pc %h instr %h expected pc %h", i, pc_d, instr_d, 32'h400 + i * 4);
            else passed++;
            cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
        end
    endtask

    task automatic test_random();
        logic [31:0] rpc;
        logic [31:0] rins;
        rpc = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            logic [31:0] ins;
            ins = $urandom;
            total++;
            if (count !== 3'(mq.size()) || valid_d !== (mq.size() > 0) || ready_f !== (mq.size() < DEPTH))
                $display("FAIL rand_status_%0d: got count %0d valid %b ready %b expected count %0d", i, count, valid_d, ready_f, mq.size());
            else passed++;
            rins = exp_instr();
            total++;
            if (pc_d !== exp_pc() || instr_d !== rins || op_d !== rins[6:0]
                || funct3_d !== rins[14:12] || funct7_d !== rins[31:25])
                $display("FAIL rand_head_%0d: got pc %h instr %h expected pc %h instr %h", i, pc_d, instr_d, exp_pc(), rins);
            else passed++;
            cycle($urandom_range(0, 3) != 0, rpc, ins, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 59) != 0);
            rpc = rpc + 32'h4;
        end
    endtask

    initial begin
        mq.delete();
        @(negedge clk);
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
